// File: rtl/seq_det_sched.sv
// Round-robin scheduler feeding one requester's serial frame at a time into a Moore "11" detector.
// Grant one cycle after IDLE sees req; done pulses one cycle after the last accept or the req drop.
module seq_det_sched (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] len,
  input  logic [3:0]  bit_in,
  input  logic [3:0]  bit_valid,
  output logic [3:0]  gnt,
  output logic        bit_ready,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [3:0]  hits,
  output logic        aborted,
  output logic [1:0]  det_state,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {DET_A = 2'b00, DET_B = 2'b01, DET_C = 2'b11} det_t;

  state_t     state, state_nxt;
  det_t       det, det_nxt, det_step;
  logic [1:0] g, g_nxt;
  logic [1:0] rr_ptr, rr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] hit_cnt, hit_nxt;
  logic       abort_q, abort_nxt;
  logic [1:0] sel;
  logic       sel_vld;
  logic       acc;
  logic       cur_bit;

  // Walk offsets from high to low so the closest requester to rr_ptr wins.
  always_comb begin
    logic [1:0] idx;
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + i[1:0];
      if (req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  assign cur_bit = bit_in[g];
  assign acc     = (state == RUN) && bit_valid[g];

  always_comb begin
    det_step = DET_A;
    if (cur_bit) begin
      case (det)
        DET_A:   det_step = DET_B;
        DET_B:   det_step = DET_C;
        DET_C:   det_step = DET_C;
        default: det_step = DET_A;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    det_nxt   = det;
    g_nxt     = g;
    rr_nxt    = rr_ptr;
    cnt_nxt   = cnt;
    hit_nxt   = hit_cnt;
    abort_nxt = abort_q;
    case (state)
      IDLE: begin
        if (sel_vld) begin
          g_nxt     = sel;
          cnt_nxt   = len[{sel, 2'b00} +: 4];
          det_nxt   = DET_A;
          hit_nxt   = '0;
          abort_nxt = 1'b0;
          state_nxt = (len[{sel, 2'b00} +: 4] == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (acc) begin
          det_nxt = det_step;
          cnt_nxt = cnt - 4'd1;
          if (det_step == DET_C && hit_cnt != 4'hF) hit_nxt = hit_cnt + 4'd1;
        end
        // A bit accepted alongside the req drop still counts above.
        if (!req[g]) begin
          abort_nxt = 1'b1;
          state_nxt = DONE;
        end else if (acc && cnt == 4'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        rr_nxt    = g + 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      det     <= DET_A;
      g       <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      hit_cnt <= '0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      det     <= det_nxt;
      g       <= g_nxt;
      rr_ptr  <= rr_nxt;
      cnt     <= cnt_nxt;
      hit_cnt <= hit_nxt;
      abort_q <= abort_nxt;
    end
  end

  assign gnt       = (state == RUN) ? (4'b0001 << g) : 4'b0000;
  assign bit_ready = (state == RUN);
  assign done      = (state == DONE);
  assign done_id   = (state == DONE) ? g : 2'd0;
  assign hits      = (state == DONE) ? hit_cnt : 4'd0;
  assign aborted   = (state == DONE) && abort_q;
  assign det_state = det;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed checks of seq_det_sched: grant order, detection counts, zero-length, abort and reset.
module tb_seq_det_sched;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  bit_in;
  logic [3:0]  bit_valid;
  logic [3:0]  gnt;
  logic        bit_ready;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  hits;
  logic        aborted;
  logic [1:0]  det_state;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seq_det_sched dut (
    .clk(clk), .resetn(resetn), .req(req), .len(len), .bit_in(bit_in),
    .bit_valid(bit_valid), .gnt(gnt), .bit_ready(bit_ready), .done(done),
    .done_id(done_id), .hits(hits), .aborted(aborted), .det_state(det_state),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = '0; len = '0; bit_in = '0; bit_valid = '0;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = '0; len = '0; bit_in = '0; bit_valid = '0;
    #1;
    checks++; if ({gnt, bit_ready, done, done_id, hits, aborted, det_state, busy} !== 16'h0) begin
      errors++; $display("FAIL reset_outputs: got gnt=%b rdy=%b done=%b id=%0d hits=%0d ab=%b det=%b busy=%b want all 0",
                         gnt, bit_ready, done, done_id, hits, aborted, det_state, busy); end
    step();
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    logic [4:0] seq;
    seq = 5'b10111;  // bit k of the frame is seq[k]: 1,1,1,0,1
    do_reset();
    req = 4'b0001; len = 16'h0005; bit_valid = 4'b0001; bit_in = {3'b000, seq[0]};
    step();
    for (int k = 0; k < 5; k++) begin
      bit_in = {3'b000, seq[k]};
      if (k == 0) len = 16'h0002;
      checks++; if (gnt !== 4'b0001 || bit_ready !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL basic_run[%0d]: got gnt=%b rdy=%b done=%b want 0001/1/0", k, gnt, bit_ready, done); end
      step();
    end
    checks++; if (done !== 1'b1 || done_id !== 2'd0 || hits !== 4'd2 || aborted !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL basic_done: got done=%b id=%0d hits=%0d ab=%b gnt=%b want 1/0/2/0/0000",
                         done, done_id, hits, aborted, gnt); end
    req = '0; bit_valid = '0;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || hits !== 4'd0) begin
      errors++; $display("FAIL basic_idle: got done=%b busy=%b hits=%0d want 0/0/0", done, busy, hits); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    do_reset();
    req = 4'b1111; len = 16'h1111; bit_valid = 4'b1111; bit_in = '0;
    for (int n = 0; n < 5; n++) begin
      exp_id = n[1:0];
      step();
      checks++; if (gnt !== (4'b0001 << exp_id)) begin
        errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, 4'b0001 << exp_id); end
      step();
      checks++; if (done !== 1'b1 || done_id !== exp_id || gnt !== 4'b0000) begin
        errors++; $display("FAIL rr_done[%0d]: got done=%b id=%0d gnt=%b want 1/%0d/0000", n, done, done_id, gnt, exp_id); end
      if (n == 4) req = '0;
      step();
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || done !== 1'b0) begin
        errors++; $display("FAIL rr_idle[%0d]: got busy=%b gnt=%b done=%b want 0/0000/0", n, busy, gnt, done); end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    req = 4'b0100; len = 16'h0000; bit_valid = 4'b0100; bit_in = 4'b0100;
    checks++; if (bit_ready !== 1'b0) begin
      errors++; $display("FAIL zlen_idle_rdy: got %b want 0", bit_ready); end
    step();
    checks++; if (done !== 1'b1 || done_id !== 2'd2 || hits !== 4'd0 || bit_ready !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL zlen_done: got done=%b id=%0d hits=%0d rdy=%b gnt=%b want 1/2/0/0/0000",
                         done, done_id, hits, bit_ready, gnt); end
    req = '0;
    step();
    checks++; if (bit_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zlen_after: got rdy=%b busy=%b want 0/0", bit_ready, busy); end
  endtask

  task automatic test_toggle_valid();
    int acc;
    logic [1:0] exp_det;
    do_reset();
    req = 4'b0010; len = 16'h00F0; bit_in = 4'b1111; bit_valid = '0;
    step();
    acc = 0;
    for (int c = 0; c < 40 && acc < 15; c++) begin
      bit_valid = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      exp_det = (acc == 0) ? 2'b00 : (acc == 1) ? 2'b01 : 2'b11;
      checks++; if (det_state !== exp_det || bit_ready !== 1'b1) begin
        errors++; $display("FAIL toggle_det[%0d]: got det=%b rdy=%b want %b/1", c, det_state, bit_ready, exp_det); end
      step();
      if (c % 2 == 0) acc++;
    end
    bit_valid = '0;
    checks++; if (done !== 1'b1 || done_id !== 2'd1 || hits !== 4'd14 || aborted !== 1'b0) begin
      errors++; $display("FAIL toggle_done: got done=%b id=%0d hits=%0d ab=%b want 1/1/14/0", done, done_id, hits, aborted); end
    req = '0;
    step();
  endtask

  task automatic test_abort();
    do_reset();
    req = 4'b1000; len = 16'h8000; bit_valid = 4'b1000; bit_in = 4'b1000;
    step();
    checks++; if (gnt !== 4'b1000) begin
      errors++; $display("FAIL abort_gnt: got %b want 1000", gnt); end
    step(); step(); step();
    req = '0; bit_valid = '0;
    checks++; if (done !== 1'b0 || bit_ready !== 1'b1) begin
      errors++; $display("FAIL abort_pre: got done=%b rdy=%b want 0/1", done, bit_ready); end
    step();
    checks++; if (done !== 1'b1 || aborted !== 1'b1 || hits !== 4'd2 || done_id !== 2'd3) begin
      errors++; $display("FAIL abort_done: got done=%b ab=%b hits=%0d id=%0d want 1/1/2/3", done, aborted, hits, done_id); end
    req = 4'b1001; len = 16'h1001;
    step();
    checks++; if (gnt !== 4'b0000 || aborted !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got gnt=%b ab=%b want 0000/0", gnt, aborted); end
    step();
    checks++; if (gnt !== 4'b0001) begin
      errors++; $display("FAIL abort_rrptr: got gnt=%b want 0001", gnt); end
    req = '0;
    step();
    step();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req = 4'b0001; len = 16'h0005; bit_valid = 4'b0001; bit_in = 4'b0001;
    step(); step(); step();
    #2;
    resetn = 1'b0;
    #1;
    checks++; if ({gnt, bit_ready, done, done_id, hits, aborted, det_state, busy} !== 16'h0) begin
      errors++; $display("FAIL midrst_outputs: got gnt=%b rdy=%b done=%b det=%b busy=%b want all 0",
                         gnt, bit_ready, done, det_state, busy); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL midrst_hold[%0d]: got done=%b busy=%b want 0/0", i, done, busy); end
    end
    resetn = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001 || det_state !== 2'b00) begin
      errors++; $display("FAIL midrst_regrant: got gnt=%b det=%b want 0001/00", gnt, det_state); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (done !== 1'b1 || hits !== 4'd4 || done_id !== 2'd0 || aborted !== 1'b0) begin
      errors++; $display("FAIL midrst_done: got done=%b hits=%0d id=%0d ab=%b want 1/4/0/0", done, hits, done_id, aborted); end
    req = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_len();
    test_toggle_valid();
    test_abort();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port req  input  4  req[i] high: requester i wants one frame analysed; held until done or abandoned.
REQ-004 SHALL have port len  input  16  len[4i+3:4i] is the frame length in bits (0..15) for requester i; sampled at grant.
REQ-005 SHALL have port bit_in  input  4  serial data bit from requester i.
REQ-006 SHALL have port bit_valid  input  4  bit_in[i] valid this cycle.
REQ-007 SHALL have port gnt  output  4  one-hot grant, all-zero when idle.
REQ-008 SHALL have port bit_ready  output  1  high while the scheduler accepts bits from the granted requester.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking frame end.
REQ-010 SHALL have port done_id  output  2  index of the finished requester, valid with done.
REQ-011 SHALL have port hits  output  4  number of "11" detections in the finished frame, valid with done.
REQ-012 SHALL have port aborted  output  1  high with done when the frame ended because req dropped.
REQ-013 SHALL have port det_state  output  2  current internal detector state.
REQ-014 SHALL have port busy  output  1  high whenever the control FSM is not IDLE.

Function
REQ-015 SHALL implement a control FSM with states IDLE, RUN and DONE.
REQ-016 SHALL contain a Moore "two consecutive ones" detector with states A=00, B=01, C=11:
  - A: 1->B, 0->A.
  - B: 1->C, 0->A.
  - C: 1->C, 0->A.
REQ-017 SHALL advance the detector only on an accepted bit (bit_valid[g] & bit_ready, g = granted index); it SHALL hold otherwise.
REQ-018 SHALL, in IDLE with any req bit high, select the first requesting index at or after rr_ptr (modulo 4) as g.
REQ-019 SHALL, at that selection edge: set gnt one-hot to g, load bit counter from len[g], force the detector to A, clear the hit counter; next state RUN, or DONE if len[g]==0.
REQ-020 SHALL drive bit_ready=1 only in RUN; bit_valid from non-granted requesters SHALL be ignored.
REQ-021 SHALL decrement the bit counter on each accepted bit; the accept that brings it to 0 SHALL move the FSM to DONE at that edge.
REQ-022 SHALL increment the hit counter on each accepted bit whose detector next state is C (accepted 1 while in B or C); it SHALL saturate at 15.
REQ-023 SHALL, in DONE (exactly one cycle): done=1, done_id=g, hits=final count, gnt=0, bit_ready=0; next state IDLE; rr_ptr <= g+1 (modulo 4).
REQ-024 SHALL, if req[g] falls while in RUN: move to DONE at the next edge with aborted=1 and hits = count so far; a bit accepted in that same cycle SHALL still be counted.
REQ-025 SHALL never assert more than one gnt bit; the first grant after DONE SHALL occur no earlier than the cycle after DONE (the IDLE cycle).
REQ-026 SHALL hold done_id, hits and aborted at 0 outside DONE.
REQ-027 SHALL drive det_state from the detector register at all times.
REQ-028 SHALL drive busy high whenever the FSM is in RUN or DONE.
REQ-029 SHALL ignore changes to len[g] after the grant edge.

Reset
REQ-030 SHALL, on resetn low: FSM=IDLE, detector=A, rr_ptr=0, bit counter=0, hit counter=0.
REQ-031 SHALL, on resetn low: gnt, bit_ready, done, done_id, hits, aborted, busy and det_state all 0, independent of clk.
REQ-032 SHALL, on reset mid-frame: discard the frame with no done pulse; operation resumes from IDLE on the first clk edge after resetn rises.

Verification
REQ-033 SHALL pass this case: req=0001, len0=5, bits 1,1,1,0,1 valid every cycle -> gnt=0001 for 5 RUN cycles, then done=1, done_id=0, hits=2, aborted=0.
REQ-034 SHALL pass this case: req=1111, all len=1 -> grants in order 0,1,2,3,0; each done separated by one IDLE cycle.
REQ-035 SHALL pass this case: req=0100, len2=0 -> IDLE->DONE directly, done_id=2, hits=0, bit_ready never high.
REQ-036 SHALL pass this case: req=0010, len1=15, all-ones bits with bit_valid toggling 1/0 -> hits=14; detector holds on invalid cycles.
REQ-037 SHALL pass this case: req[3] dropped after 3 accepted bits 1,1,1 -> done with aborted=1, hits=2, rr_ptr=0.
REQ-038 SHALL pass this case: resetn pulsed low during RUN -> all outputs 0 immediately, no done pulse; a later req=0001 is granted normally.
